// File: rtl/i2c_poll_seq.sv
// Periodic / triggered single-register poller that sequences a byte-level I2C master.
// Optional build macro I2C_POLL_RETRY_EN: retry a failed poll up to 3 times before reporting it.
module i2c_poll_seq #(
    parameter logic [6:0] DEV_ADDR    = 7'h70,
    parameter logic [7:0] REG_ADDR    = 8'hB2,
    parameter int         POLL_PERIOD = 64,
    parameter int         TIMEOUT     = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       trig,
    output logic [6:0] m_address,
    output logic [7:0] m_register,
    output logic       m_mode,
    output logic       m_en,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_repeat_start,
    input  logic [7:0] m_out,
    input  logic       m_ack,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       busy,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_period_cnt;
    logic [7:0]  r_tmo_cnt;
    logic        r_stop_cnt;
    logic        r_fail;
    logic        r_m_en;
    logic        r_m_start;
    logic        r_m_stop;
    logic        r_busy;
    logic [7:0]  r_data;
    logic        r_data_valid;
    logic        r_err;
    logic [7:0]  r_err_cnt;
    logic        w_retry;

`ifdef I2C_POLL_RETRY_EN
    logic [1:0]  r_retry_cnt;
    assign w_retry = r_fail && (r_retry_cnt != 2'd3);
`else
    assign w_retry = 1'b0;
`endif

    assign m_address      = DEV_ADDR;
    assign m_register     = REG_ADDR;
    assign m_mode         = 1'b1;
    assign m_repeat_start = 1'b0;
    assign m_en           = r_m_en;
    assign m_start        = r_m_start;
    assign m_stop         = r_m_stop;
    assign busy           = r_busy;
    assign data           = r_data;
    assign data_valid     = r_data_valid;
    assign err            = r_err;
    assign err_cnt        = r_err_cnt;

    // Poll sequencer; outputs are registered so they always match the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_period_cnt <= 16'd0;
            r_tmo_cnt    <= 8'd0;
            r_stop_cnt   <= 1'b0;
            r_fail       <= 1'b0;
            r_m_en       <= 1'b0;
            r_m_start    <= 1'b0;
            r_m_stop     <= 1'b0;
            r_busy       <= 1'b0;
            r_data       <= 8'd0;
            r_data_valid <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= 8'd0;
`ifdef I2C_POLL_RETRY_EN
            r_retry_cnt  <= 2'd0;
`endif
        end else begin
            r_data_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // trig and period terminal together still launch a single poll
                    if (trig || (enable && (r_period_cnt == 16'(POLL_PERIOD - 1)))) begin
                        r_state      <= ST_START;
                        r_period_cnt <= 16'd0;
                        r_m_en       <= 1'b1;
                        r_m_start    <= 1'b1;
                        r_busy       <= 1'b1;
                    end else if (enable) begin
                        r_period_cnt <= r_period_cnt + 16'd1;
                    end else begin
                        r_period_cnt <= 16'd0;
                    end
                end
                ST_START: begin
                    r_tmo_cnt <= 8'd0;
                    r_fail    <= 1'b0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_ack) begin
                        r_data       <= m_out;
                        r_data_valid <= 1'b1;
                        r_fail       <= 1'b0;
                        r_state      <= ST_STOP;
                        r_stop_cnt   <= 1'b0;
                        r_m_start    <= 1'b0;
                        r_m_stop     <= 1'b1;
                    end else if (r_tmo_cnt == 8'(TIMEOUT - 1)) begin
                        r_fail       <= 1'b1;
                        r_state      <= ST_STOP;
                        r_stop_cnt   <= 1'b0;
                        r_m_start    <= 1'b0;
                        r_m_stop     <= 1'b1;
                    end else begin
                        r_tmo_cnt    <= r_tmo_cnt + 8'd1;
                    end
                end
                ST_STOP: begin
                    if (r_stop_cnt == 1'b0) begin
                        r_stop_cnt <= 1'b1;
                    end else if (w_retry) begin
                        r_state    <= ST_START;
                        r_m_start  <= 1'b1;
                        r_m_stop   <= 1'b0;
`ifdef I2C_POLL_RETRY_EN
                        r_retry_cnt <= r_retry_cnt + 2'd1;
`endif
                    end else begin
                        r_state      <= ST_IDLE;
                        r_period_cnt <= 16'd0;
                        r_m_en       <= 1'b0;
                        r_m_stop     <= 1'b0;
                        r_busy       <= 1'b0;
`ifdef I2C_POLL_RETRY_EN
                        r_retry_cnt  <= 2'd0;
`endif
                        if (r_fail) begin
                            r_err <= 1'b1;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end else begin
                                r_err_cnt <= r_err_cnt;
                            end
                        end else begin
                            r_err <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_m_en    <= 1'b0;
                    r_m_start <= 1'b0;
                    r_m_stop  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
